muxpga_cfg_loader: RTL and testbench

//  Transmit end of the MUXPGA configuration interface. Accepts one full configuration

---
 rtl/muxpga_cfg_pkg.sv | 16 +
 rtl/muxpga_cfg_tick.sv | 61 ++++++
 rtl/muxpga_cfg_loader.sv | 164 ++++++++++++++++
 tb/tb_muxpga_cfg_loader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muxpga_cfg_pkg.sv
// Shared definitions for the MUXPGA configuration interface.
// Used by the transmit-side loader and by the fabric-side shift receiver so
// both ends agree on state encodings and the default tile word width.
package muxpga_cfg_pkg;

    localparam int MUXPGA_CFG_BITS = 32;
    localparam int MUXPGA_CLK_DIV  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/muxpga_cfg_tick.sv
// Phase timer for the config serializer.
// A down-counter that times one sclk period (2*CLK_DIV cycles) per bit, or
// CLK_DIV cycles for the latch pulse, and owns the registered sclk level.
//   clk, rst     system clock, synchronous active-high reset
//   load_bit     start a new bit period: counter = 2*CLK_DIV-1, sclk low
//   load_latch   start the latch period: counter = CLK_DIV-1, sclk low
//   run          count down one step (stops at zero, never wraps)
//   sclk         registered shift clock level
//   phase_end    last cycle of the sclk low half-period
//   bit_end      counter at terminal count (last cycle of the period)
module muxpga_cfg_tick
    import muxpga_cfg_pkg::*;
#(
    parameter int CLK_DIV = MUXPGA_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load_bit,
    input  logic load_latch,
    input  logic run,
    output logic sclk,
    output logic phase_end,
    output logic bit_end
);

    localparam int PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] BIT_LOAD   = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] LATCH_LOAD = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] HALF       = PW'(CLK_DIV);
    localparam logic [PW-1:0] CNT_ONE    = PW'(1);

    logic [PW-1:0] cnt_q;
    logic          sclk_q;

    // Counter values above HALF are the low phase, HALF marks the last low
    // cycle, so sclk rises on the edge that leaves HALF.
    assign phase_end = (cnt_q == HALF);
    assign bit_end   = (cnt_q == '0);
    assign sclk      = sclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (load_bit) begin
            cnt_q  <= BIT_LOAD;
            sclk_q <= 1'b0;
        end else if (load_latch) begin
            cnt_q  <= LATCH_LOAD;
            sclk_q <= 1'b0;
        end else if (run) begin
            if (phase_end) begin
                sclk_q <= 1'b1;
            end
            if (!bit_end) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/muxpga_cfg_loader.sv
// Transmit end of the MUXPGA configuration interface.
// Takes one CFG_BITS word over valid/ready and shifts it MSB-first onto the
// fabric config pins, then pulses latch so the fabric applies it.
//   clk, rst     system clock, synchronous active-high reset
//   word_valid   source has a word on word_data
//   word_ready   loader idle; word taken when valid && ready at posedge
//   word_data    configuration word, MSB shifted first
//   cfg_sclk     shift clock to fabric (fabric samples on rising edge)
//   cfg_sdata    serial data to fabric
//   cfg_latch    apply strobe to fabric, CLK_DIV cycles long
//   busy         high from the cycle after accept through done
//   done         one-cycle pulse after latch completes
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready high, waiting for a word
// ST_SHIFT | driving bits out, one sclk period per bit
// ST_LATCH | sclk/sdata low, latch high for CLK_DIV cycles
// ST_DONE  | done pulse, busy still high, ready low
module muxpga_cfg_loader
    import muxpga_cfg_pkg::*;
#(
    parameter int CFG_BITS = MUXPGA_CFG_BITS,
    parameter int CLK_DIV  = MUXPGA_CLK_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                word_valid,
    output logic                word_ready,
    input  logic [CFG_BITS-1:0] word_data,
    output logic                cfg_sclk,
    output logic                cfg_sdata,
    output logic                cfg_latch,
    output logic                busy,
    output logic                done
);

    localparam int BW = $clog2(CFG_BITS + 1);
    localparam logic [BW-1:0] BIT_TOTAL = BW'(CFG_BITS);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    cfg_state_t          state_q, state_d;
    logic [CFG_BITS-1:0] shreg_q, shreg_d, shreg_shl;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                sdata_q, sdata_d;
    logic                latch_q, latch_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;

    logic                load_bit, load_latch, tick_run;
    logic                tick_sclk, phase_end, bit_end;

    muxpga_cfg_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .load_bit   (load_bit),
        .load_latch (load_latch),
        .run        (tick_run),
        .sclk       (tick_sclk),
        .phase_end  (phase_end),
        .bit_end    (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sdata_q   <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sdata_q   <= sdata_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    // Every output is computed one cycle ahead here and registered above,
    // so the pins carry no combinational path from word_valid.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        sdata_d    = sdata_q;
        latch_d    = latch_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ready_d    = ready_q;
        load_bit   = 1'b0;
        load_latch = 1'b0;
        tick_run   = 1'b0;
        shreg_shl  = shreg_q << 1;

        case (state_q)
            ST_IDLE: begin
                if (word_valid && ready_q) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = word_data;
                    bit_cnt_d = BIT_TOTAL;
                    sdata_d   = word_data[CFG_BITS-1];
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                    load_bit  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_ONE) begin
                        state_d    = ST_LATCH;
                        bit_cnt_d  = '0;
                        sdata_d    = 1'b0;
                        latch_d    = 1'b1;
                        load_latch = 1'b1;
                    end else begin
                        // New bit lands on the same edge sclk falls.
                        shreg_d   = shreg_shl;
                        sdata_d   = shreg_shl[CFG_BITS-1];
                        bit_cnt_d = bit_cnt_q - BIT_ONE;
                        load_bit  = 1'b1;
                    end
                end else begin
                    tick_run = 1'b1;
                end
            end
            ST_LATCH: begin
                if (bit_end) begin
                    state_d = ST_DONE;
                    latch_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    tick_run = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign word_ready = ready_q;
    assign cfg_sclk   = tick_sclk;
    assign cfg_sdata  = sdata_q;
    assign cfg_latch  = latch_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Directed bench for muxpga_cfg_loader: instance A (8 bits, CLK_DIV=2) and
// instance B (32 bits, CLK_DIV=1). Inputs change and outputs are sampled on
// the falling edge; cycle n is the period following rising edge n.
module tb_muxpga_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, valid_a, ready_a, sclk_a, sdata_a, latch_a, busy_a, done_a;
    logic [7:0] data_a;
    logic        rst_b, valid_b, ready_b, sclk_b, sdata_b, latch_b, busy_b, done_b;
    logic [31:0] data_b;

    muxpga_cfg_loader #(.CFG_BITS(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst_a), .word_valid(valid_a), .word_ready(ready_a),
        .word_data(data_a), .cfg_sclk(sclk_a), .cfg_sdata(sdata_a),
        .cfg_latch(latch_a), .busy(busy_a), .done(done_a)
    );

    muxpga_cfg_loader #(.CFG_BITS(32), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .word_valid(valid_b), .word_ready(ready_b),
        .word_data(data_b), .cfg_sclk(sclk_b), .cfg_sdata(sdata_b),
        .cfg_latch(latch_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    logic h_sclk [0:127];
    logic h_sdata[0:127];
    logic h_latch[0:127];
    logic h_busy [0:127];
    logic h_done [0:127];
    logic h_ready[0:127];
    int   rise_cyc[0:63];
    int   rises, latch_cnt, latch_first, latch_last, done_cnt, done_cyc;
    int   ready_first, busy_cnt, sdata_bad;
    logic [31:0] rx;

    task automatic sample_cycle(input bit sel, input int n);
        if (sel) begin
            h_sclk[n] = sclk_b; h_sdata[n] = sdata_b; h_latch[n] = latch_b;
            h_busy[n] = busy_b; h_done[n]  = done_b;  h_ready[n] = ready_b;
        end else begin
            h_sclk[n] = sclk_a; h_sdata[n] = sdata_a; h_latch[n] = latch_a;
            h_busy[n] = busy_a; h_done[n]  = done_a;  h_ready[n] = ready_a;
        end
    endtask

    task automatic drive(input bit sel, input bit v, input bit d_en,
                         input logic [31:0] d, input bit r);
        if (sel) begin
            valid_b = v; rst_b = r;
            if (d_en) data_b = d;
        end else begin
            valid_a = v; rst_a = r;
            if (d_en) data_a = d[7:0];
        end
    endtask

    // Caller sets inputs for cycle 0 at a falling edge, then calls this.
    // From cycle 1 on, valid = v_base except v_val inside [v_cyc, v_cyc+v_len).
    task automatic observe(input bit sel, input int ncyc, input bit v_base,
                           input int v_cyc, input int v_len, input bit v_val,
                           input int d_cyc, input logic [31:0] d_val, input int rst_cyc);
        bit v;
        rises = 0; rx = '0; latch_cnt = 0; latch_first = -1; latch_last = -1;
        done_cnt = 0; done_cyc = -1; ready_first = -1; busy_cnt = 0; sdata_bad = 0;
        for (int i = 0; i < 64; i++) rise_cyc[i] = -1;
        sample_cycle(sel, 0);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            sample_cycle(sel, n);
            if (h_sclk[n] === 1'b1 && h_sclk[n-1] === 1'b0) begin
                if (rises < 64) rise_cyc[rises] = n;
                rises++;
                rx = {rx[30:0], h_sdata[n]};
            end
            if (h_sdata[n] !== h_sdata[n-1] && h_sclk[n] !== 1'b0) sdata_bad++;
            if (h_latch[n] === 1'b1) begin
                if (latch_first < 0) latch_first = n;
                latch_last = n;
                latch_cnt++;
            end
            if (h_done[n] === 1'b1) begin
                if (done_cyc < 0) done_cyc = n;
                done_cnt++;
            end
            if (h_ready[n] === 1'b1 && ready_first < 0) ready_first = n;
            if (h_busy[n] === 1'b1) busy_cnt++;
            v = (n >= v_cyc && n < v_cyc + v_len) ? v_val : v_base;
            drive(sel, v, (n == d_cyc), d_val, (n == rst_cyc));
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1; valid_a = 1'b1; valid_b = 1'b1;
        data_a = 8'hFF; data_b = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++; if ({ready_a,busy_a,done_a,latch_a,sclk_a,sdata_a} !== 6'b100000) begin errors++; $display("FAIL rst_hold_a: got %b expected 100000", {ready_a,busy_a,done_a,latch_a,sclk_a,sdata_a}); end
        checks++; if ({ready_b,busy_b,done_b,latch_b,sclk_b,sdata_b} !== 6'b100000) begin errors++; $display("FAIL rst_hold_b: got %b expected 100000", {ready_b,busy_b,done_b,latch_b,sclk_b,sdata_b}); end
        rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        #1;
        checks++; if ({ready_a,busy_a,done_a,latch_a,sclk_a,sdata_a} !== 6'b100000) begin errors++; $display("FAIL rst_release_a: got %b expected 100000", {ready_a,busy_a,done_a,latch_a,sclk_a,sdata_a}); end
        checks++; if ({ready_b,busy_b,done_b,latch_b,sclk_b,sdata_b} !== 6'b100000) begin errors++; $display("FAIL rst_release_b: got %b expected 100000", {ready_b,busy_b,done_b,latch_b,sclk_b,sdata_b}); end
        @(negedge clk);
        checks++; if ({ready_a,busy_a} !== 2'b10) begin errors++; $display("FAIL rst_idle_a: got %b expected 10", {ready_a,busy_a}); end
    endtask

    task automatic test_single_word;
        valid_a = 1'b1; data_a = 8'hA5;
        observe(1'b0, 40, 1'b0, 0, 0, 1'b0, -1, 32'h0, -1);
        checks++; if (h_ready[0] !== 1'b1) begin errors++; $display("FAIL t1_ready_c0: got %b expected 1", h_ready[0]); end
        checks++; if ({h_busy[1],h_ready[1],h_sclk[1],h_sdata[1]} !== 4'b1001) begin errors++; $display("FAIL t1_c1: got %b expected 1001", {h_busy[1],h_ready[1],h_sclk[1],h_sdata[1]}); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL t1_rises: got %0d expected 8", rises); end
        checks++; if (rx !== 32'hA5) begin errors++; $display("FAIL t1_bits: got %h expected a5", rx); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rise_cyc[i] !== 3 + 4*i) begin errors++; $display("FAIL t1_rise%0d: got cycle %0d expected %0d", i, rise_cyc[i], 3 + 4*i); end
        end
        checks++; if (latch_cnt !== 2 || latch_first !== 33 || latch_last !== 34) begin errors++; $display("FAIL t1_latch: got cnt %0d cycles %0d-%0d expected cnt 2 cycles 33-34", latch_cnt, latch_first, latch_last); end
        checks++; if ({h_sclk[33],h_sdata[33],h_sclk[34],h_sdata[34]} !== 4'b0000) begin errors++; $display("FAIL t1_latch_pins: got %b expected 0000", {h_sclk[33],h_sdata[33],h_sclk[34],h_sdata[34]}); end
        checks++; if (done_cnt !== 1 || done_cyc !== 35) begin errors++; $display("FAIL t1_done: got cnt %0d cycle %0d expected cnt 1 cycle 35", done_cnt, done_cyc); end
        checks++; if ({h_busy[35],h_ready[35]} !== 2'b10) begin errors++; $display("FAIL t1_done_cycle: got busy/ready %b expected 10", {h_busy[35],h_ready[35]}); end
        checks++; if (ready_first !== 36 || h_busy[36] !== 1'b0) begin errors++; $display("FAIL t1_ready_back: got cycle %0d busy %b expected cycle 36 busy 0", ready_first, h_busy[36]); end
        checks++; if (busy_cnt !== 35) begin errors++; $display("FAIL t1_busy_len: got %0d expected 35", busy_cnt); end
        checks++; if (sdata_bad !== 0) begin errors++; $display("FAIL t1_sdata_stable: got %0d changes while sclk high expected 0", sdata_bad); end
    endtask

    task automatic test_back_to_back;
        valid_a = 1'b1; data_a = 8'h3C;
        observe(1'b0, 36, 1'b1, 0, 0, 1'b0, 5, 32'hC3, -1);
        checks++; if (rx !== 32'h3C || rises !== 8) begin errors++; $display("FAIL t2_first_word: got %h rises %0d expected 3c rises 8", rx, rises); end
        checks++; if (latch_cnt !== 2 || latch_first !== 33 || done_cyc !== 35) begin errors++; $display("FAIL t2_first_latch: got latch %0d@%0d done@%0d expected 2@33 done@35", latch_cnt, latch_first, done_cyc); end
        checks++; if (h_ready[36] !== 1'b1) begin errors++; $display("FAIL t2_ready36: got %b expected 1", h_ready[36]); end
        observe(1'b0, 36, 1'b0, 0, 0, 1'b0, -1, 32'h0, -1);
        checks++; if ({h_busy[1],h_ready[1]} !== 2'b10) begin errors++; $display("FAIL t2_second_accept: got busy/ready %b expected 10", {h_busy[1],h_ready[1]}); end
        checks++; if (rx !== 32'hC3 || rises !== 8) begin errors++; $display("FAIL t2_second_word: got %h rises %0d expected c3 rises 8", rx, rises); end
        checks++; if (latch_cnt !== 2 || latch_first !== 33 || done_cyc !== 35) begin errors++; $display("FAIL t2_second_latch: got latch %0d@%0d done@%0d expected 2@33 done@35", latch_cnt, latch_first, done_cyc); end
    endtask

    task automatic test_reset_mid_load;
        valid_a = 1'b1; data_a = 8'hF0;
        observe(1'b0, 40, 1'b0, 0, 0, 1'b0, -1, 32'h0, 10);
        checks++; if ({h_ready[11],h_busy[11],h_done[11],h_latch[11],h_sclk[11],h_sdata[11]} !== 6'b100000) begin errors++; $display("FAIL t3_c11: got %b expected 100000", {h_ready[11],h_busy[11],h_done[11],h_latch[11],h_sclk[11],h_sdata[11]}); end
        checks++; if (latch_cnt !== 0 || done_cnt !== 0) begin errors++; $display("FAIL t3_no_commit: got latch %0d done %0d expected 0 0", latch_cnt, done_cnt); end
        checks++; if (rises !== 2 || busy_cnt !== 10) begin errors++; $display("FAIL t3_abort: got rises %0d busy %0d expected 2 10", rises, busy_cnt); end
        valid_a = 1'b1; data_a = 8'h96;
        observe(1'b0, 36, 1'b0, 0, 0, 1'b0, -1, 32'h0, -1);
        checks++; if (rx !== 32'h96 || latch_first !== 33 || done_cyc !== 35) begin errors++; $display("FAIL t3_reload: got %h latch@%0d done@%0d expected 96 latch@33 done@35", rx, latch_first, done_cyc); end
    endtask

    task automatic test_valid_while_busy;
        valid_a = 1'b1; data_a = 8'h5A;
        observe(1'b0, 40, 1'b0, 20, 1, 1'b1, 20, 32'hFF, -1);
        checks++; if (done_cnt !== 1 || done_cyc !== 35) begin errors++; $display("FAIL t4_done: got cnt %0d cycle %0d expected cnt 1 cycle 35", done_cnt, done_cyc); end
        checks++; if (rx !== 32'h5A) begin errors++; $display("FAIL t4_word: got %h expected 5a", rx); end
        checks++; if (busy_cnt !== 35 || h_busy[37] !== 1'b0 || h_ready[37] !== 1'b1) begin errors++; $display("FAIL t4_no_capture: got busy %0d busy37 %b ready37 %b expected 35 0 1", busy_cnt, h_busy[37], h_ready[37]); end
    endtask

    task automatic test_clkdiv1_wide;
        int bad;
        valid_b = 1'b1; data_b = 32'hFFFF_0001;
        observe(1'b1, 70, 1'b0, 0, 0, 1'b0, -1, 32'h0, -1);
        bad = 0;
        for (int n = 1; n <= 64; n++) if (h_sclk[n] !== ((n % 2) == 0)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL t5_toggle: got %0d wrong sclk cycles expected 0", bad); end
        checks++; if (rises !== 32 || rise_cyc[0] !== 2 || rise_cyc[31] !== 64) begin errors++; $display("FAIL t5_rises: got %0d first %0d last %0d expected 32 2 64", rises, rise_cyc[0], rise_cyc[31]); end
        checks++; if (rx !== 32'hFFFF_0001) begin errors++; $display("FAIL t5_word: got %h expected ffff0001", rx); end
        checks++; if (latch_cnt !== 1 || latch_first !== 65) begin errors++; $display("FAIL t5_latch: got cnt %0d cycle %0d expected 1 65", latch_cnt, latch_first); end
        checks++; if (done_cnt !== 1 || done_cyc !== 66 || ready_first !== 67) begin errors++; $display("FAIL t5_done: got done %0d@%0d ready@%0d expected 1@66 ready@67", done_cnt, done_cyc, ready_first); end
        checks++; if (sdata_bad !== 0) begin errors++; $display("FAIL t5_sdata_stable: got %0d expected 0", sdata_bad); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_reset_mid_load();
        test_valid_while_busy();
        test_clkdiv1_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
